// File: rtl/mem_ref_sequencer.sv
// Multi-cycle sequencer for LC-3 memory-reference instructions (LD/LDI/LDR/ST/STI/STR/LEA).
// Drives the address-calc selects, holds MAR/MDR, runs a req/ack memory handshake with a
// per-access timeout watchdog, and issues the register-file / condition-code write strobe.
module mem_ref_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_instr,
    input  logic [15:0] i_addr_in,
    input  logic [15:0] i_marmux_in,
    input  logic [15:0] i_sr_data,
    output logic        o_addr1_sel,
    output logic [1:0]  o_addr2_sel,
    output logic        o_marmux_sel,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_rf_we,
    output logic [15:0] o_rf_wdata,
    output logic        o_ld_cc,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_IND  = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_WB   = 3'd5;
    localparam logic [2:0] ST_FIN  = 3'd6;

    // Timer value on the last permitted no-ack cycle of an access.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            OP_LD, OP_LDI, OP_LDR, OP_ST, OP_STI, OP_STR, OP_LEA: is_mem_op = 1'b1;
            default:                                              is_mem_op = 1'b0;
        endcase
    endfunction

    logic [2:0]  r_state;
    logic [3:0]  r_op;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic [7:0]  r_timer;
    logic        r_err;

    logic [2:0]  w_state_nxt;
    logic [3:0]  w_op_nxt;
    logic [15:0] w_mar_nxt;
    logic [15:0] w_mdr_nxt;
    logic [7:0]  w_timer_nxt;
    logic        w_err_nxt;
    logic        w_pc_rel;
    logic        w_base_rel;

    // Only the opcode steers this block; DR/offset fields are consumed elsewhere.
    logic w_unused_instr;
    assign w_unused_instr = ^i_instr[11:0];

    assign w_pc_rel   = (r_op == OP_LD) || (r_op == OP_LDI) || (r_op == OP_ST) ||
                        (r_op == OP_STI) || (r_op == OP_LEA);
    assign w_base_rel = (r_op == OP_LDR) || (r_op == OP_STR);

    // Next-state, MAR/MDR loading and handshake watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_mar_nxt   = r_mar;
        w_mdr_nxt   = r_mdr;
        w_timer_nxt = r_timer;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_op_nxt    = i_instr[15:12];
                    w_err_nxt   = 1'b0;
                    w_timer_nxt = 8'd0;
                    // Non-memory opcodes complete immediately without touching memory.
                    w_state_nxt = is_mem_op(i_instr[15:12]) ? ST_CALC : ST_FIN;
                end
            end
            ST_CALC: begin
                w_mar_nxt = i_addr_in;
                case (r_op)
                    OP_LEA: begin
                        // Capture the LEA result now while the selects are still driven.
                        w_mdr_nxt   = i_marmux_in;
                        w_state_nxt = ST_WB;
                    end
                    OP_LDI, OP_STI: w_state_nxt = ST_IND;
                    OP_LD, OP_LDR:  w_state_nxt = ST_RD;
                    OP_ST, OP_STR: begin
                        w_mdr_nxt   = i_sr_data;
                        w_state_nxt = ST_WR;
                    end
                    default:        w_state_nxt = ST_FIN;
                endcase
            end
            ST_IND, ST_RD, ST_WR: begin
                if (i_mem_ack) begin
                    w_timer_nxt = 8'd0;
                    case (r_state)
                        ST_IND: begin
                            w_mar_nxt = i_mem_rdata;
                            if (r_op == OP_STI) begin
                                w_mdr_nxt   = i_sr_data;
                                w_state_nxt = ST_WR;
                            end else begin
                                w_state_nxt = ST_RD;
                            end
                        end
                        ST_RD: begin
                            w_mdr_nxt   = i_mem_rdata;
                            w_state_nxt = ST_WB;
                        end
                        default: w_state_nxt = ST_FIN;
                    endcase
                end else if (r_timer == TIMER_LAST) begin
                    // Abort: skip any write-back, still signal completion.
                    w_err_nxt   = 1'b1;
                    w_timer_nxt = 8'd0;
                    w_state_nxt = ST_FIN;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            ST_WB:   w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops every output asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= 4'd0;
            r_mar   <= 16'd0;
            r_mdr   <= 16'd0;
            r_timer <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_mar   <= w_mar_nxt;
            r_mdr   <= w_mdr_nxt;
            r_timer <= w_timer_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        o_addr1_sel  = 1'b0;
        o_addr2_sel  = 2'd3;
        o_marmux_sel = 1'b0;
        if (r_state == ST_CALC) begin
            if (w_pc_rel) begin
                o_addr1_sel = 1'b1;
                o_addr2_sel = 2'd1;
            end else if (w_base_rel) begin
                o_addr2_sel = 2'd2;
            end
        end
        o_mem_req   = (r_state == ST_IND) || (r_state == ST_RD) || (r_state == ST_WR);
        o_mem_we    = (r_state == ST_WR);
        o_mem_addr  = r_mar;
        o_mem_wdata = (r_state == ST_WR) ? r_mdr : 16'd0;
        o_rf_we     = (r_state == ST_WB);
        o_rf_wdata  = (r_state == ST_WB) ? r_mdr : 16'd0;
        o_ld_cc     = (r_state == ST_WB);
        o_busy      = (r_state != ST_IDLE);
        o_done      = (r_state == ST_FIN);
        o_err       = r_err;
    end

endmodule

// File: tb/tb_mem_ref_sequencer.sv
// Randomized bench for mem_ref_sequencer with a transaction-level reference model.
module tb_mem_ref_sequencer;

    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;
    logic [15:0] addr_in;
    logic [15:0] marmux_in;
    logic [15:0] sr_data;
    logic        addr1_sel;
    logic [1:0]  addr2_sel;
    logic        marmux_sel;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic        ld_cc;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks;
    int n_bad;

    mem_ref_sequencer #(
        .TIMEOUT(TO)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_instr     (instr),
        .i_addr_in   (addr_in),
        .i_marmux_in (marmux_in),
        .i_sr_data   (sr_data),
        .o_addr1_sel (addr1_sel),
        .o_addr2_sel (addr2_sel),
        .o_marmux_sel(marmux_sel),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .o_rf_we     (rf_we),
        .o_rf_wdata  (rf_wdata),
        .o_ld_cc     (ld_cc),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one instruction. d0/d1 are ack delays (cycles of req before ack) for the
    // first/second access; NEVER means no ack. rd0/rd1 are the read data returned.
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] a_in,
                             input logic [15:0] mmx, input logic [15:0] sr,
                             input int d0, input int d1,
                             input logic [15:0] rd0, input logic [15:0] rd1,
                             input bit perturb);
        logic [3:0]  op;
        int          n_acc;
        logic [15:0] acc_addr [2];
        logic        acc_we   [2];
        int          acc_d    [2];
        logic [15:0] acc_rd   [2];
        bit          is_mem;
        bit          pc_rel;
        bit          exp_rf;
        logic [15:0] exp_rf_data;
        bit          exp_err;
        int          exp_lat;
        int          acc;
        int          cnt;
        int          n_seen;
        int          rf_n;
        int          ld_n;
        logic [15:0] rf_val;
        int          done_cyc;

        op          = ins[15:12];
        n_acc       = 0;
        is_mem      = 1'b1;
        pc_rel      = 1'b1;
        exp_rf      = 1'b0;
        exp_rf_data = 16'd0;
        exp_err     = 1'b0;
        acc_d[0]    = d0;
        acc_d[1]    = d1;
        acc_rd[0]   = rd0;
        acc_rd[1]   = rd1;
        acc_addr[0] = a_in;
        acc_addr[1] = rd0;
        acc_we[0]   = 1'b0;
        acc_we[1]   = 1'b0;
        case (op)
            4'b0010, 4'b0110: begin
                n_acc = 1; exp_rf = 1'b1; exp_rf_data = rd0; pc_rel = (op == 4'b0010);
            end
            4'b1010: begin n_acc = 2; exp_rf = 1'b1; exp_rf_data = rd1; end
            4'b0011, 4'b0111: begin
                n_acc = 1; acc_we[0] = 1'b1; pc_rel = (op == 4'b0011);
            end
            4'b1011: begin n_acc = 2; acc_we[1] = 1'b1; end
            4'b1110: begin exp_rf = 1'b1; exp_rf_data = mmx; end
            default: is_mem = 1'b0;
        endcase

        if (is_mem) begin
            exp_lat = 1;
            for (int k = 0; k < 2; k++) begin
                if (k < n_acc && !exp_err) begin
                    if (acc_d[k] >= TO) begin
                        exp_lat += TO;
                        exp_err  = 1'b1;
                        exp_rf   = 1'b0;
                        n_acc    = k + 1;
                    end else begin
                        exp_lat += acc_d[k] + 1;
                    end
                end
            end
            if (exp_rf) exp_lat += 1;
            exp_lat += 1;
        end else begin
            exp_lat = 1;
        end

        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        instr     = ins;
        addr_in   = a_in;
        marmux_in = mmx;
        sr_data   = sr;
        start     = 1'b1;
        acc = 0; cnt = 0; n_seen = 0; rf_n = 0; ld_n = 0; rf_val = 16'd0; done_cyc = -1;

        for (int cyc = 1; cyc <= exp_lat + 4 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start   = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
            if (perturb) instr = 16'($urandom);
            mem_ack = 1'b0;
            if (cyc == 1) begin
                check_eq("err_cleared", 32'(err), 32'd0);
                check_eq("marmux_sel", 32'(marmux_sel), 32'd0);
                if (is_mem) begin
                    check_eq("addr1_sel", 32'(addr1_sel), pc_rel ? 32'd1 : 32'd0);
                    check_eq("addr2_sel", 32'(addr2_sel), pc_rel ? 32'd1 : 32'd2);
                end
            end
            if (mem_req) begin
                if (acc >= n_acc) begin
                    check_eq("extra_req", 32'd1, 32'd0);
                end else begin
                    if (cnt == 0) n_seen++;
                    check_eq("mem_addr", 32'(mem_addr), 32'(acc_addr[acc]));
                    check_eq("mem_we", 32'(mem_we), 32'(acc_we[acc]));
                    if (acc_we[acc]) check_eq("mem_wdata", 32'(mem_wdata), 32'(sr));
                    if (cnt == acc_d[acc]) begin
                        mem_ack   = 1'b1;
                        mem_rdata = acc_rd[acc];
                        acc++;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else if (perturb && $urandom_range(0, 3) == 0) begin
                // Stray ack while idle on the port must be ignored.
                mem_ack   = 1'b1;
                mem_rdata = 16'($urandom);
            end
            if (rf_we) begin
                rf_n++;
                rf_val = rf_wdata;
            end
            if (ld_cc) ld_n++;
            if (done) done_cyc = cyc;
        end
        mem_ack = 1'b0;
        start   = 1'b0;

        check_eq("latency", 32'(done_cyc), 32'(exp_lat));
        check_eq("n_access", 32'(n_seen), 32'(n_acc));
        check_eq("rf_we_cnt", 32'(rf_n), exp_rf ? 32'd1 : 32'd0);
        check_eq("ld_cc_cnt", 32'(ld_n), exp_rf ? 32'd1 : 32'd0);
        if (exp_rf) check_eq("rf_wdata", 32'(rf_val), 32'(exp_rf_data));
        check_eq("err_done", 32'(err), 32'(exp_err));
        @(negedge clk);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("done_after", 32'(done), 32'd0);
        check_eq("err_sticky", 32'(err), 32'(exp_err));
    endtask

    logic [3:0] mem_ops [7];

    initial begin
        n_checks  = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        instr     = 16'd0;
        addr_in   = 16'd0;
        marmux_in = 16'd0;
        sr_data   = 16'd0;
        mem_rdata = 16'd0;
        mem_ack   = 1'b0;
        mem_ops   = '{4'b0010, 4'b1010, 4'b0110, 4'b0011, 4'b1011, 4'b0111, 4'b1110};

        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr2", 32'(addr2_sel), 32'd3);
        check_eq("rst_addr1", 32'(addr1_sel), 32'd0);
        check_eq("rst_maddr", 32'(mem_addr), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_instr(16'h2205, 16'h3006, 16'h0, 16'h0, 2, 0, 16'hBEEF, 16'h0, 1'b0);
        run_instr(16'hA401, 16'h3002, 16'h0, 16'h0, 0, 0, 16'h4000, 16'h1234, 1'b0);
        run_instr(16'h7283, 16'h5555, 16'h0, 16'h00FF, 0, 0, 16'h0, 16'h0, 1'b0);
        run_instr(16'hE0FF, 16'h3100, 16'h3100, 16'h0, 0, 0, 16'h0, 16'h0, 1'b0);
        run_instr(16'h2205, 16'h3006, 16'h0, 16'h0, NEVER, 0, 16'h0, 16'h0, 1'b0);
        run_instr(16'hE0FF, 16'hFFFF, 16'h0042, 16'h0, 0, 0, 16'h0, 16'h0, 1'b0);
        run_instr(16'h3001, 16'hABCD, 16'h0, 16'h1357, TO - 1, 0, 16'h0, 16'h0, 1'b0);
        run_instr(16'hB123, 16'h0100, 16'h0, 16'h2468, 1, NEVER, 16'h0200, 16'h0, 1'b0);
        run_instr(16'h0000, 16'h0000, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1'b0);
        run_instr(16'h6283, 16'h7777, 16'h0, 16'h0, 1, 0, 16'hCAFE, 16'h0, 1'b1);

        // Reset during a read access with req high.
        @(negedge clk);
        instr   = 16'h2205;
        addr_in = 16'h3006;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_req", 32'(mem_req), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_maddr", 32'(mem_addr), 32'd0);
        check_eq("arst_addr2", 32'(addr2_sel), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized instructions.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] ins;
            int          da;
            int          db;
            ins = 16'($urandom);
            if ($urandom_range(0, 9) < 7) ins[15:12] = mem_ops[$urandom_range(0, 6)];
            da = $urandom_range(0, 3);
            db = $urandom_range(0, 3);
            case ($urandom_range(0, 11))
                0: da = NEVER;
                1: db = NEVER;
                2: da = TO - 1;
                default: ;
            endcase
            run_instr(ins, 16'($urandom), 16'($urandom), 16'($urandom), da, db,
                      16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
